// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch sequencing in front of inst_memory.
// Handles PC+4 advance, stall holds, branch/jump redirects and halt/resume.
// Optional build macro PC_MISALIGN_CHECK_EN: a misaligned redirect target traps to
// TRAP_VEC and pulses misalign_err. Without it, the low two target bits are dropped.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
`ifdef PC_MISALIGN_CHECK_EN
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
`endif
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             halt_req,
    input  logic             resume,
    output logic [31:0]      PC_out,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             booted;
    logic             booted_nxt;
    logic [31:0]      pc_nxt;
    logic             fv_nxt;
    logic             halted_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      target;
    logic             trap;

    // Link value for JAL/JALR; wraps naturally at 2^32.
    assign pc_plus4 = PC_out + 32'd4;

    // Resolve the address a redirect would actually load.
`ifdef PC_MISALIGN_CHECK_EN
    always_comb begin
        trap   = (redirect_pc[1:0] != 2'b00);
        target = trap ? TRAP_VEC : redirect_pc;
    end
`else
    logic unused_target_lsb;
    assign unused_target_lsb = ^redirect_pc[1:0];

    always_comb begin
        trap   = 1'b0;
        target = {redirect_pc[31:2], 2'b00};
    end
`endif

    // State and output registers; reset forces every output to its idle value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_BOOT;
            booted       <= 1'b0;
            PC_out       <= RESET_VEC;
            fetch_valid  <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state        <= state_nxt;
            booted       <= booted_nxt;
            PC_out       <= pc_nxt;
            fetch_valid  <= fv_nxt;
            halted       <= halted_nxt;
            misalign_err <= err_nxt;
            fetch_count  <= cnt_nxt;
        end
    end

    // Next-state, next-PC and fetch accounting.
    always_comb begin
        state_nxt  = state;
        booted_nxt = booted;
        pc_nxt     = PC_out;
        fv_nxt     = fetch_valid;
        halted_nxt = halted;
        err_nxt    = 1'b0;
        cnt_nxt    = fetch_count;

        case (state)
            ST_BOOT: begin
                // One full boot cycle after the first post-reset edge; inputs ignored.
                booted_nxt = 1'b1;
                if (booted) begin
                    state_nxt  = ST_RUN;
                    fv_nxt     = 1'b1;
                    halted_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_nxt  = target;
                    err_nxt = trap;
                end else if (!halt_req && !stall) begin
                    pc_nxt = PC_out + 32'd4;
                end
                if (redirect || !stall) begin
                    cnt_nxt = fetch_count + CNT_W'(1);
                end
                if (halt_req) begin
                    state_nxt  = ST_HALT;
                    fv_nxt     = 1'b0;
                    halted_nxt = 1'b1;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    pc_nxt  = target;
                    err_nxt = trap;
                    cnt_nxt = fetch_count + CNT_W'(1);
                end
                if (resume && !halt_req) begin
                    state_nxt  = ST_RUN;
                    fv_nxt     = 1'b1;
                    halted_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt  = ST_BOOT;
                fv_nxt     = 1'b0;
                halted_nxt = 1'b0;
            end
        endcase
    end

endmodule
